// File: rtl/capture_sampler.sv
// Strobe-triggered WIDTH x DEPTH sample buffer with FIFO/ring modes.
// Define CAPTURE_SYNC_EN to synchronise an asynchronous cap_in/din pair.
module capture_sampler #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cap_in,
    input  logic [WIDTH-1:0]           din,
    input  logic                       mode,
    input  logic                       rd_en,
    input  logic                       clr,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       cap_pulse
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic             cap_s;
    logic [WIDTH-1:0] din_s;

`ifdef CAPTURE_SYNC_EN
    logic             sync1_q, sync2_q;
    logic [WIDTH-1:0] dly1_q, dly2_q;

    // din rides a matching delay so it lines up with the synchronised strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly1_q  <= '0;
            dly2_q  <= '0;
        end else begin
            sync1_q <= cap_in;
            sync2_q <= sync1_q;
            dly1_q  <= din;
            dly2_q  <= dly1_q;
        end
    end

    assign cap_s = sync2_q;
    assign din_s = dly2_q;
`else
    assign cap_s = cap_in;
    assign din_s = din;
`endif

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             cap_q;
    logic             pulse_q;
    logic             push;
    logic             do_pop;
    logic             we;
    logic             empty_w;
    logic             full_w;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == FULL_C);
    assign push    = cap_s & ~cap_q;
    assign do_pop  = rd_en & ~empty_w;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        if (clr) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (push) begin
            if (!full_w) begin
                we   = 1'b1;
                wr_d = wr_q + 1'b1;
                if (do_pop) begin
                    rd_d = rd_q + 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else if (do_pop || mode) begin
                // full: a simultaneous pop frees the slot; ring mode evicts oldest
                we   = 1'b1;
                wr_d = wr_q + 1'b1;
                rd_d = rd_q + 1'b1;
                if (!do_pop) begin
                    ovf_d = 1'b1;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end else if (do_pop) begin
            rd_d    = rd_q + 1'b1;
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            cap_q   <= 1'b1;
            pulse_q <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            cap_q   <= cap_s;
            pulse_q <= push;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_q] <= din_s;
        end
    end

    assign dout      = empty_w ? '0 : mem_q[rd_q];
    assign count     = count_q;
    assign empty     = empty_w;
    assign full      = full_w;
    assign overflow  = ovf_q;
    assign cap_pulse = pulse_q;

endmodule

// File: tb/tb_capture_sampler.sv
// Directed bench for capture_sampler, default (unsynchronised) build.
module tb_capture_sampler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cap_in;
    logic [5:0] din;
    logic       mode;
    logic       rd_en;
    logic       clr;
    logic [5:0] dout;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       cap_pulse;

    int checks = 0;
    int failures = 0;

    capture_sampler #(.WIDTH(6), .DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_in    (cap_in),
        .din       (din),
        .mode      (mode),
        .rd_en     (rd_en),
        .clr       (clr),
        .dout      (dout),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .cap_pulse (cap_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cap;
        logic [5:0] d;
        logic       rd;
        logic       cl;
        logic [3:0] e_cnt;
        logic [5:0] e_dout;
        logic       e_empty;
        logic       e_pulse;
    } vec_t;

    vec_t tv [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [5:0] d);
        cap_in = 1'b0;
        din = d;
        tick();
        cap_in = 1'b1;
        tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        tv[0]  = '{1'b1, 6'h00, 1'b0, 1'b0, 4'd0, 6'h00, 1'b1, 1'b0};
        tv[1]  = '{1'b1, 6'h00, 1'b0, 1'b0, 4'd0, 6'h00, 1'b1, 1'b0};
        tv[2]  = '{1'b1, 6'h00, 1'b0, 1'b0, 4'd0, 6'h00, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 6'h2A, 1'b0, 1'b0, 4'd0, 6'h00, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 6'h2A, 1'b0, 1'b0, 4'd1, 6'h2A, 1'b0, 1'b1};
        tv[5]  = '{1'b1, 6'h00, 1'b0, 1'b0, 4'd1, 6'h2A, 1'b0, 1'b0};
        tv[6]  = '{1'b0, 6'h00, 1'b1, 1'b0, 4'd0, 6'h00, 1'b1, 1'b0};
        tv[7]  = '{1'b0, 6'h00, 1'b1, 1'b0, 4'd0, 6'h00, 1'b1, 1'b0};
        tv[8]  = '{1'b1, 6'h11, 1'b1, 1'b0, 4'd1, 6'h11, 1'b0, 1'b1};
        tv[9]  = '{1'b0, 6'h00, 1'b0, 1'b0, 4'd1, 6'h11, 1'b0, 1'b0};
        tv[10] = '{1'b1, 6'h22, 1'b0, 1'b0, 4'd2, 6'h11, 1'b0, 1'b1};
        tv[11] = '{1'b0, 6'h00, 1'b1, 1'b1, 4'd0, 6'h00, 1'b1, 1'b0};
        tv[12] = '{1'b0, 6'h00, 1'b0, 1'b0, 4'd0, 6'h00, 1'b1, 1'b0};

        rst_n = 1'b0;
        cap_in = 1'b1;
        din = '0;
        mode = 1'b0;
        rd_en = 1'b0;
        clr = 1'b0;
        tick();
        tick();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_pulse", cap_pulse, 0);
        chk("rst_dout", dout, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cap_in = tv[i].cap;
            din = tv[i].d;
            rd_en = tv[i].rd;
            clr = tv[i].cl;
            tick();
            chk($sformatf("v%0d_count", i), count, tv[i].e_cnt);
            chk($sformatf("v%0d_dout", i), dout, tv[i].e_dout);
            chk($sformatf("v%0d_empty", i), empty, tv[i].e_empty);
            chk($sformatf("v%0d_pulse", i), cap_pulse, tv[i].e_pulse);
        end
        rd_en = 1'b0;
        clr = 1'b0;

        // FIFO mode: ninth push is dropped
        mode = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            push(6'(i));
            chk($sformatf("fifo_cnt%0d", i), count, (i > 8) ? 8 : i);
            chk($sformatf("fifo_ovf%0d", i), overflow, (i > 8) ? 1 : 0);
        end
        chk("fifo_full", full, 1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("fifo_dout%0d", i), dout, i);
            pop();
        end
        chk("fifo_empty", empty, 1);
        chk("fifo_dout_empty", dout, 0);
        chk("fifo_ovf_sticky", overflow, 1);
        do_clr();
        chk("clr_ovf", overflow, 0);

        // ring mode: two oldest overwritten
        mode = 1'b1;
        for (int i = 1; i <= 10; i++) push(6'(i));
        chk("ring_cnt", count, 8);
        chk("ring_ovf", overflow, 1);
        chk("ring_full", full, 1);
        for (int i = 3; i <= 10; i++) begin
            chk($sformatf("ring_dout%0d", i), dout, i);
            pop();
        end
        chk("ring_empty", empty, 1);
        do_clr();

        // push and pop together at full
        mode = 1'b0;
        for (int i = 1; i <= 8; i++) push(6'(i));
        chk("pp_full", full, 1);
        cap_in = 1'b0;
        tick();
        cap_in = 1'b1;
        din = 6'h30;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pp_cnt", count, 8);
        chk("pp_ovf", overflow, 0);
        chk("pp_pulse", cap_pulse, 1);
        for (int i = 2; i <= 8; i++) begin
            chk($sformatf("pp_dout%0d", i), dout, i);
            pop();
        end
        chk("pp_newest", dout, 6'h30);
        chk("pp_cnt1", count, 1);
        pop();
        pop();
        chk("empty_pop_cnt", count, 0);
        chk("empty_pop_empty", empty, 1);
        chk("empty_pop_ovf", overflow, 0);
        chk("empty_pop_dout", dout, 0);

        // clr beats a simultaneous push and pop
        for (int i = 1; i <= 9; i++) push(6'(i + 16));
        pop();
        pop();
        pop();
        chk("clr_pre_cnt", count, 5);
        chk("clr_pre_ovf", overflow, 1);
        cap_in = 1'b0;
        tick();
        cap_in = 1'b1;
        din = 6'h3C;
        rd_en = 1'b1;
        clr = 1'b1;
        tick();
        rd_en = 1'b0;
        clr = 1'b0;
        chk("clr_cnt", count, 0);
        chk("clr_empty", empty, 1);
        chk("clr_ovf2", overflow, 0);
        tick();
        chk("clr_lost_cnt", count, 0);
        chk("clr_lost_dout", dout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/capture_sampler.md
# capture_sampler

Parametrised strobe-triggered sample buffer, the successor to the fixed 6-bit pin-clocked capture latch. It samples a WIDTH-bit input bus on each rising edge of a capture strobe and stores up to DEPTH samples for later readout. The strobe is edge-detected in the system clock domain instead of clocking flops directly. It sits between the user I/O pins and downstream readout/display logic in a TinyTapeout user module.

## Interface
Parameters:
- WIDTH, 6, sample width in bits (1..16)
- DEPTH, 8, buffer entries; power of two, 2..16

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cap_in  in  1  capture strobe; a rising edge requests one sample
- din  in  WIDTH  sample data
- mode  in  1  0 = FIFO (drop when full), 1 = ring (overwrite oldest when full)
- rd_en  in  1  pop the oldest entry
- clr  in  1  synchronous clear of buffer contents and flags
- dout  out  WIDTH  oldest stored entry; all zeros when empty
- count  out  $clog2(DEPTH+1)  number of stored entries
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky; a sample was dropped or overwritten
- cap_pulse  out  1  one-cycle pulse per accepted strobe edge

## Operation
- Edge detect: cap_q holds the previous strobe value; push = cap_s & ~cap_q. cap_s is cap_in, or the synchronised strobe when CAPTURE_SYNC_EN is defined.
- Push writes din (or its delayed copy) to mem[wr_ptr]; wr_ptr wraps modulo DEPTH.
- Pop, when rd_en=1 and !empty, advances rd_ptr modulo DEPTH.
- dout is show-ahead: combinational mem[rd_ptr] gated to zero when empty.
- Priority: rst_n > clr > push/pop.
- clr zeroes pointers, count and overflow. It does not touch cap_q or the synchroniser. A push in the same cycle as clr is discarded.
- Push, not full: store; count+1.
- Push, full, no pop, mode=0: sample dropped; overflow set; count unchanged.
- Push, full, no pop, mode=1: write at wr_ptr; rd_ptr advances; overflow set; count unchanged.
- Push and pop together, not empty: both happen and count is unchanged. At full this is not an overflow in either mode.
- Push and pop together, empty: push only; the pop is ignored.
- Pop when empty: ignored. This is not an error and no flag is set.
- mode may change at any time and takes effect on the next push.
- overflow clears only on clr or reset.
- cap_pulse registers push, so it is high for the cycle after the write, including dropped pushes.

## Timing
- Reset values: pointers 0, count 0, empty 1, full 0, overflow 0, cap_pulse 0, dout 0, synchroniser flops 0.
- cap_q resets to 1. A strobe already high at reset release does not capture; it must go low and then high.
- Without sync: cap_in=1 and cap_q=0 at edge N writes din sampled at edge N. count and empty update after edge N. cap_pulse is high in cycle N+1.
- With sync: cap_in and din pass through matched 2-stage pipelines. The write occurs at edge N+2 with din as sampled at edge N. cap_pulse is high in cycle N+3.
- Pop: dout shows the next entry in the cycle after the rd_en edge.
- Strobe high or low phases shorter than one clk period (two periods with sync) may be missed.

## Configuration
- CAPTURE_SYNC_EN defined: a 2-flop synchroniser on cap_in and a matching 2-stage delay on din. This adds 2 cycles of capture latency and is safe for an asynchronous pin strobe.
- CAPTURE_SYNC_EN undefined: cap_in and din are used directly. The strobe must be synchronous to clk.

## Test plan
- Reset with cap_in=1, release, hold 3 cycles -> count=0, no cap_pulse. Drop to 0, raise with din=6'h2A -> count=1, dout=6'h2A, cap_pulse high for exactly 1 cycle.
- mode=0, DEPTH=8: push 0x01..0x09 -> full=1, overflow=1, count=8. Pop 8 times -> dout sequence 0x01..0x08, then empty=1, dout=0.
- mode=1: push 0x01..0x0A -> count=8, overflow=1. Pops -> dout 0x03..0x0A.
- At full, push and pop in the same cycle (mode=0) -> count stays 8, overflow stays 0, newest entry stored. When empty, pop alone -> no state change.
- Pop asserted with clr in the same cycle as a push, at count=5, overflow=1 -> count=0, empty=1, overflow=0, pushed sample lost.
- CAPTURE_SYNC_EN: cap_in rises at edge N with din=0x15, din changes to 0x3F at edge N+1 -> stored value 0x15, count increments after edge N+2.
